// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: op-codes, FSM states and op classification shared by
// logic_unit_seq and the ALU decoder.
// Optional feature macro: LOGIC_UNIT_POPCNT_EN (enables op 1110 = POPCNT).
package logic_unit_pkg;

   localparam int unsigned OP_W = 4;

   localparam logic [OP_W-1:0] OP_AND    = 4'b0011;
   localparam logic [OP_W-1:0] OP_OR     = 4'b0100;
   localparam logic [OP_W-1:0] OP_XOR    = 4'b0101;
   localparam logic [OP_W-1:0] OP_NOT    = 4'b0110;
   localparam logic [OP_W-1:0] OP_NAND   = 4'b0111;
   localparam logic [OP_W-1:0] OP_NOR    = 4'b1000;
   localparam logic [OP_W-1:0] OP_XNOR   = 4'b1001;
   localparam logic [OP_W-1:0] OP_SHL    = 4'b1010;
   localparam logic [OP_W-1:0] OP_SHR    = 4'b1011;
   localparam logic [OP_W-1:0] OP_ROL    = 4'b1100;
   localparam logic [OP_W-1:0] OP_ROR    = 4'b1101;
   localparam logic [OP_W-1:0] OP_POPCNT = 4'b1110;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CLS_LOGIC   = 2'd0,
      CLS_SHIFT   = 2'd1,
      CLS_POPCNT  = 2'd2,
      CLS_ILLEGAL = 2'd3
   } op_class_t;

   // Result flags, registered alongside the result
   typedef struct packed {
      logic zero;
      logic parity;
      logic carry;
      logic err;
   } flags_t;

   // Classify an op-code; POPCNT is legal only when the feature is built in
   function automatic op_class_t classify_op(input logic [OP_W-1:0] op);
      op_class_t cls;
      cls = CLS_ILLEGAL;
      case (op)
         OP_AND, OP_OR, OP_XOR, OP_NOT,
         OP_NAND, OP_NOR, OP_XNOR:        cls = CLS_LOGIC;
         OP_SHL, OP_SHR, OP_ROL, OP_ROR:  cls = CLS_SHIFT;
`ifdef LOGIC_UNIT_POPCNT_EN
         OP_POPCNT:                       cls = CLS_POPCNT;
`endif
         default:                         cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/logic_unit_seq_if.sv
// logic_unit_seq_if: operand/result handshake bundle for logic_unit_seq.
// master = operand/decode side, slave = the logic unit.
interface logic_unit_seq_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       op_sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             parity;
   logic             carry;
   logic             err;

   modport master (
      output in_valid, A, B, op_sel, out_ready,
      input  in_ready, out_valid, result, zero, parity, carry, err
   );

   modport slave (
      input  in_valid, A, B, op_sel, out_ready,
      output in_ready, out_valid, result, zero, parity, carry, err
   );
endinterface

// File: rtl/shift_step.sv
// shift_step: one-position shift or rotate of the working register.
// Left/right selected by i_left; i_rot feeds the leaving bit back in,
// otherwise the vacated position is zero-filled.
module shift_step #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] i_val,
   input  logic             i_left,
   input  logic             i_rot,
   output logic [WIDTH-1:0] o_val,
   output logic             o_out
);

   // Single-step shift/rotate and the bit that leaves the register
   always_comb begin
      o_val = i_val;
      o_out = 1'b0;
      if (i_left) begin
         o_out = i_val[WIDTH-1];
         o_val = {i_val[WIDTH-2:0], i_rot & i_val[WIDTH-1]};
      end else begin
         o_out = i_val[0];
         o_val = {i_rot & i_val[0], i_val[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/logic_unit_seq.sv
// logic_unit_seq: handshaked logic unit with multi-cycle shift/rotate and
// registered result flags (zero, parity, carry, err).
// Optional feature macro: LOGIC_UNIT_POPCNT_EN (op 1110 = count of ones in A).
module logic_unit_seq
   import logic_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   logic_unit_seq_if.slave bus
);

   // Shift amount width is derived from WIDTH
   localparam int unsigned SAW = $clog2(WIDTH);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_work;
   logic [WIDTH-1:0] r_result;
   logic [SAW-1:0]   r_cnt;
   logic             r_left;
   logic             r_rot;
   flags_t           r_flags;

   logic [WIDTH-1:0] w_imm;
   logic [WIDTH-1:0] w_step;
   logic             w_step_out;
   logic [SAW-1:0]   w_amt;
   op_class_t        w_cls;
   logic             w_shift_go;
   logic             w_accept;
   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_last_step;

   assign w_amt       = bus.B[SAW-1:0];
   assign w_cls       = classify_op(bus.op_sel);
   assign w_shift_go  = (w_cls == CLS_SHIFT) && (w_amt != '0);
   assign w_accept    = bus.in_valid & w_in_ready;
   assign w_last_step = (r_state == ST_SHIFT) && (r_cnt <= SAW'(1));

`ifdef LOGIC_UNIT_POPCNT_EN
   logic [WIDTH-1:0] w_popcnt;

   // Number of ones in A, zero-extended to the result width
   always_comb begin
      int unsigned v_cnt;
      v_cnt = 0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         v_cnt = v_cnt + 32'(bus.A[i]);
      end
      w_popcnt = WIDTH'(v_cnt);
   end
`endif

   // Single-cycle result: logic ops, shifts by zero, popcount, illegal (0)
   always_comb begin
      w_imm = '0;
      case (bus.op_sel)
         OP_AND:  w_imm = bus.A & bus.B;
         OP_OR:   w_imm = bus.A | bus.B;
         OP_XOR:  w_imm = bus.A ^ bus.B;
         OP_NOT:  w_imm = ~bus.A;
         OP_NAND: w_imm = ~(bus.A & bus.B);
         OP_NOR:  w_imm = ~(bus.A | bus.B);
         OP_XNOR: w_imm = ~(bus.A ^ bus.B);
         OP_SHL, OP_SHR,
         OP_ROL, OP_ROR: w_imm = bus.A;
`ifdef LOGIC_UNIT_POPCNT_EN
         OP_POPCNT: w_imm = w_popcnt;
`endif
         default: w_imm = '0;
      endcase
   end

   shift_step #(
      .WIDTH (WIDTH)
   ) u_shift_step (
      .i_val  (r_work),
      .i_left (r_left),
      .i_rot  (r_rot),
      .o_val  (w_step),
      .o_out  (w_step_out)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next-state: DONE may consume and re-accept on the same edge
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next = w_shift_go ? ST_SHIFT : ST_DONE;
            end
         end
         ST_SHIFT: begin
            if (w_last_step) begin
               w_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (w_accept) begin
               w_next = w_shift_go ? ST_SHIFT : ST_DONE;
            end else if (bus.out_ready) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // FSM outputs: handshake controls decoded from the state register
   always_comb begin
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_in_ready = 1'b1;
         end
         ST_DONE: begin
            w_out_valid = 1'b1;
            w_in_ready  = bus.out_ready;
         end
         default: begin
            w_in_ready  = 1'b0;
            w_out_valid = 1'b0;
         end
      endcase
   end

   // Datapath: capture operands on accept, step shifts, register result+flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_work   <= '0;
         r_result <= '0;
         r_cnt    <= '0;
         r_left   <= 1'b0;
         r_rot    <= 1'b0;
         r_flags  <= '0;
      end else if (w_accept) begin
         if (w_shift_go) begin
            r_work <= bus.A;
            r_cnt  <= w_amt;
            r_left <= (bus.op_sel == OP_SHL) || (bus.op_sel == OP_ROL);
            r_rot  <= (bus.op_sel == OP_ROL) || (bus.op_sel == OP_ROR);
         end else begin
            r_result       <= w_imm;
            r_flags.zero   <= ~|w_imm;
            r_flags.parity <= ^w_imm;
            r_flags.carry  <= 1'b0;
            r_flags.err    <= (w_cls == CLS_ILLEGAL);
         end
      end else if (r_state == ST_SHIFT) begin
         r_work <= w_step;
         r_cnt  <= r_cnt - SAW'(1);
         if (w_last_step) begin
            r_result       <= w_step;
            r_flags.zero   <= ~|w_step;
            r_flags.parity <= ^w_step;
            r_flags.carry  <= w_step_out;
            r_flags.err    <= 1'b0;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.result    = r_result;
   assign bus.zero      = r_flags.zero;
   assign bus.parity    = r_flags.parity;
   assign bus.carry     = r_flags.carry;
   assign bus.err       = r_flags.err;

endmodule
